// File: rtl/gray_conv_pipe.sv
// gray_conv_pipe: two-stage pipelined binary<->Gray converter with valid/ready
// handshakes on both sides, a per-word direction bit and a single-step
// adjacency checker for Gray-coded input streams.
module gray_conv_pipe #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_mode,
  output logic [DW-1:0] o_data,
  output logic          o_step_err,
  output logic          o_err_sticky,
  input  logic          i_err_clr
);

  // Binary to Gray: each output bit is the XOR of two neighbouring input bits.
  function automatic logic [DW-1:0] bin2gray(input logic [DW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB down.
  function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
    logic [DW-1:0] b;
    b[DW-1] = g[DW-1];
    for (int k = DW - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // True when more than one bit is set (Hamming distance above one step).
  function automatic logic multi_bit(input logic [DW-1:0] x);
    logic [31:0] cnt;
    cnt = 32'd0;
    for (int k = 0; k < DW; k++) begin
      cnt = cnt + {31'd0, x[k]};
    end
    return (cnt > 32'd1);
  endfunction

  // Stage 1: raw captured word plus its step-check result
  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q,  s1_mode_d;
  logic          s1_err_q,   s1_err_d;
  logic [DW-1:0] s1_data_q,  s1_data_d;
  // Stage 2: converted word driving the outputs
  logic          s2_valid_q, s2_valid_d;
  logic          s2_mode_q,  s2_mode_d;
  logic          s2_err_q,   s2_err_d;
  logic [DW-1:0] s2_data_q,  s2_data_d;
  // Sticky error and adjacency checker history
  logic          sticky_q,   sticky_d;
  logic          prev_vld_q, prev_vld_d;
  logic [DW-1:0] prev_gray_q, prev_gray_d;

  logic s2_load_s;
  logic s1_load_s;
  logic accept_s;
  logic step_err_s;

  // Handshake and load enables; o_ready follows i_ready combinationally.
  always_comb begin
    s2_load_s  = !s2_valid_q || i_ready;
    s1_load_s  = !s1_valid_q || s2_load_s;
    o_ready    = s1_load_s && !i_rst;
    accept_s   = i_valid && o_ready;
    step_err_s = i_mode && prev_vld_q && multi_bit(i_data ^ prev_gray_q);
  end

  // Next-state for both pipeline stages, the sticky flag and checker history.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_err_d    = s1_err_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_err_d    = s2_err_q;
    s2_data_d   = s2_data_q;
    sticky_d    = sticky_q;
    prev_vld_d  = prev_vld_q;
    prev_gray_d = prev_gray_q;

    if (s1_load_s) begin
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_mode_d = i_mode;
        s1_err_d  = step_err_s;
        s1_data_d = i_data;
      end else begin
        s1_err_d  = 1'b0;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_err_d  = s1_err_q;
        s2_data_d = s1_mode_q ? gray2bin(s1_data_q) : bin2gray(s1_data_q);
      end else begin
        s2_err_d  = 1'b0;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Setting wins over a simultaneous clear so no error is ever lost.
    if (s2_load_s && s1_valid_q && s1_err_q) begin
      sticky_d = 1'b1;
    end else if (i_err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    // Only accepted Gray-mode words advance the adjacency history.
    if (accept_s && i_mode) begin
      prev_gray_d = i_data;
      prev_vld_d  = 1'b1;
    end else begin
      prev_gray_d = prev_gray_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_data_q   <= '0;
      sticky_q    <= 1'b0;
      prev_vld_q  <= 1'b0;
      prev_gray_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_err_q    <= s2_err_d;
      s2_data_q   <= s2_data_d;
      sticky_q    <= sticky_d;
      prev_vld_q  <= prev_vld_d;
      prev_gray_q <= prev_gray_d;
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_mode       = s2_mode_q;
  assign o_data       = s2_data_q;
  assign o_step_err   = s2_err_q;
  assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed self-checking bench for gray_conv_pipe (DW=8).
module tb_gray_conv_pipe;

  logic       i_clk, i_rst, i_valid, o_ready, i_mode, o_valid, i_ready;
  logic       o_mode, o_step_err, o_err_sticky, i_err_clr;
  logic [7:0] i_data, o_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst_first;
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic       err;
    logic       sticky;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] src_a[256];
  logic [7:0] exp_a[256];
  logic [7:0] cap_a[256];

  gray_conv_pipe #(.DW(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_mode(o_mode), .o_data(o_data), .o_step_err(o_step_err),
    .o_err_sticky(o_err_sticky), .i_err_clr(i_err_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] g_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_err_clr = 1'b0; i_ready = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // One isolated word: accept now, expect it on the outputs two cycles later.
  task automatic apply_word(input string tag, input logic mode, input logic [7:0] din,
                            input logic [7:0] dout, input logic err, input logic sticky);
    i_valid = 1'b1; i_mode = mode; i_data = din;
    #1;
    chk({tag, " o_ready"}, o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    chk({tag, " not-yet-valid"}, o_valid, 1'b0);
    tick();
    chk({tag, " o_valid"}, o_valid, 1'b1);
    chk({tag, " o_data"}, o_data, dout);
    chk({tag, " o_mode"}, o_mode, mode);
    chk({tag, " o_step_err"}, o_step_err, err);
    chk({tag, " o_err_sticky"}, o_err_sticky, sticky);
  endtask

  // Stream src_a[0..255] back-to-back and compare each output with exp_a.
  task automatic run_stream(input string tag, input logic mode);
    int idx = 0;
    int out_n = 0;
    int acc_win = 0;
    for (int cyc = 0; cyc < 262; cyc++) begin
      tick();
      if (o_valid) begin
        if (out_n < 256) begin
          chk($sformatf("%s data[%0d]", tag, out_n), o_data, exp_a[out_n]);
          chk($sformatf("%s step_err[%0d]", tag, out_n), o_step_err, 1'b0);
          cap_a[out_n] = o_data;
        end
        out_n++;
      end
      i_valid = (idx < 256);
      i_mode  = mode;
      i_data  = src_a[idx % 256];
      #1;
      if (i_valid && o_ready) begin
        idx++;
        if (cyc < 256) acc_win++;
      end
    end
    i_valid = 1'b0;
    chk({tag, " accepts in 256 cycles"}, acc_win, 256);
    chk({tag, " outputs"}, out_n, 256);
  endtask

  initial begin
    logic       hold_pend;
    logic [7:0] held;
    int         sent, got;
    logic       rdy;

    i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = 8'h00;
    i_ready = 1'b1; i_err_clr = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 8'h2D, 8'h3B, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h3B, 8'h2D, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 8'h80, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h07, 8'h05, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h06, 8'h04, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h80, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h55, 8'h7F, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};

    // Reset state while reset is held
    #2;
    chk("rst o_valid", o_valid, 1'b0);
    chk("rst o_data", o_data, 8'h00);
    chk("rst o_mode", o_mode, 1'b0);
    chk("rst o_step_err", o_step_err, 1'b0);
    chk("rst o_err_sticky", o_err_sticky, 1'b0);
    chk("rst o_ready", o_ready, 1'b0);
    do_reset();

    // Table-driven single words; sticky-clear sequence inserted before entry 10
    for (int i = 0; i < 14; i++) begin
      if (i == 10) begin
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr alone sticky", o_err_sticky, 1'b0);
        i_valid = 1'b1; i_mode = 1'b1; i_data = 8'hF0;
        tick();
        i_valid = 1'b0; i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("set+clr o_valid", o_valid, 1'b1);
        chk("set+clr o_data", o_data, 8'hA0);
        chk("set+clr o_step_err", o_step_err, 1'b1);
        chk("set+clr sticky", o_err_sticky, 1'b1);
      end
      if (vecs[i].rst_first) do_reset();
      apply_word($sformatf("vec%0d", i), vecs[i].mode, vecs[i].din,
                 vecs[i].dout, vecs[i].err, vecs[i].sticky);
    end

    // Exhaustive round trip: binary->Gray, then the captured Gray back
    do_reset();
    for (int k = 0; k < 256; k++) begin
      src_a[k] = k[7:0];
      exp_a[k] = g_of(k[7:0]);
    end
    run_stream("b2g", 1'b0);
    for (int k = 0; k < 256; k++) begin
      src_a[k] = cap_a[k];
      exp_a[k] = k[7:0];
    end
    run_stream("g2b", 1'b1);
    tick();
    chk("roundtrip sticky", o_err_sticky, 1'b0);

    // Back-pressure: continuous input, i_ready low in cycles 3..5
    do_reset();
    hold_pend = 1'b0; held = 8'h00; sent = 0; got = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      tick();
      rdy = !(cyc >= 3 && cyc <= 5);
      i_ready = rdy;
      i_valid = (sent < 12);
      i_mode  = 1'b0;
      i_data  = 8'h10 + sent[7:0];
      #1;
      if (hold_pend) begin
        chk($sformatf("bp hold valid c%0d", cyc), o_valid, 1'b1);
        chk($sformatf("bp hold data c%0d", cyc), o_data, held);
        hold_pend = 1'b0;
      end
      if (cyc <= 10) chk($sformatf("bp o_ready c%0d", cyc), o_ready, (cyc < 2) ? 1'b1 : rdy);
      if (o_valid && i_ready) begin
        chk($sformatf("bp order %0d", got), o_data, g_of(8'h10 + got[7:0]));
        got++;
      end
      if (o_valid && !i_ready) begin
        hold_pend = 1'b1;
        held = o_data;
      end
      if (i_valid && o_ready) sent++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp sent", sent, 12);
    chk("bp received", got, 12);

    // Reset mid-stream with two words in flight
    do_reset();
    i_valid = 1'b1; i_mode = 1'b1; i_data = 8'h0F;
    tick();
    i_data = 8'h0E;
    tick();
    i_valid = 1'b0;
    chk("mid in-flight valid", o_valid, 1'b1);
    i_rst = 1'b1;
    #1;
    chk("mid rst o_valid", o_valid, 1'b0);
    chk("mid rst o_data", o_data, 8'h00);
    chk("mid rst o_ready", o_ready, 1'b0);
    tick();
    chk("mid rst held o_ready", o_ready, 1'b0);
    chk("mid rst held o_valid", o_valid, 1'b0);
    tick();
    i_rst = 1'b0;
    apply_word("post-rst AA", 1'b1, 8'hAA, 8'hCC, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
